// File: rtl/ibex_xif_compressed_arbiter_pkg.sv
// ============================================================================
// Module : ibex_xif_compressed_arbiter_pkg
// Brief  : XIF compressed-interface types and arbiter state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ibex_xif_compressed_arbiter_pkg;

  typedef struct packed {
    logic [15:0] instr;
    logic [1:0]  mode;
    logic [3:0]  id;
  } x_compressed_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } x_compressed_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  localparam int unsigned XIF_ARB_STAT_W = 16;

  function automatic logic [XIF_ARB_STAT_W-1:0] stat_sat_inc(
    input logic [XIF_ARB_STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_xif_compressed_arbiter_rr_picker.sv
// ============================================================================
// Module : ibex_rr_picker
// Brief  : Combinational round-robin picker; first set request at or after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ibex_rr_picker #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);

  int          j;
  logic [IW-1:0] idx;

  // Scan farthest offset first so the closest match to ptr overwrites it last.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    j           = 0;
    idx         = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_i) + k;
      if (j >= int'(N)) j = j - int'(N);
      idx = IW'(j);
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ibex_xif_compressed_arbiter.sv
// ============================================================================
// Module : ibex_xif_compressed_arbiter
// Brief  : Round-robin share of one XIF compressed decoder with issue timeout.
//          Optional per-requester statistics: XIF_COMP_ARB_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ibex_xif_compressed_arbiter
  import ibex_xif_compressed_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  x_compressed_req_t [NUM_REQ-1:0]   req_i,
  output x_compressed_resp_t                resp_o,
  output logic                              dn_valid_o,
  input  logic                              dn_ready_i,
  output x_compressed_req_t                 dn_req_o,
  input  x_compressed_resp_t                dn_resp_i
`ifdef XIF_COMP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*XIF_ARB_STAT_W-1:0] stat_accept_o,
  output logic [NUM_REQ*XIF_ARB_STAT_W-1:0] stat_reject_o
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  x_compressed_req_t  dn_req_q, dn_req_d;
  x_compressed_resp_t resp_q, resp_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  ibex_rr_picker #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_picker (
    .req_i       (req_valid_i),
    .ptr_i       (ptr_q),
    .gnt_valid_o (pick_valid),
    .gnt_idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    timer_d  = timer_q;
    dn_req_d = dn_req_q;
    resp_d   = resp_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          dn_req_d = req_i[pick_idx];
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // A handshake on the final allowed cycle still counts as a real response.
        if (dn_ready_i) begin
          resp_d  = dn_resp_i;
          state_d = ARB_RESP;
        end else if (TMO_EN && (timer_q == TMR_LAST)) begin
          resp_d  = '0;
          state_d = ARB_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ARB_RESP: begin
        ptr_d   = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
        timer_d = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      timer_q  <= '0;
      dn_req_q <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      timer_q  <= timer_d;
      dn_req_q <= dn_req_d;
      resp_q   <= resp_d;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == ARB_RESP) req_ready_o[grant_q] = 1'b1;
  end

  assign resp_o     = (state_q == ARB_RESP) ? resp_q : '0;
  assign dn_valid_o = (state_q == ARB_ISSUE);
  assign dn_req_o   = dn_req_q;

`ifdef XIF_COMP_ARB_STATS_EN
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
    logic [XIF_ARB_STAT_W-1:0] acc_q, acc_d;
    logic [XIF_ARB_STAT_W-1:0] rej_q, rej_d;

    always_comb begin
      acc_d = acc_q;
      rej_d = rej_q;
      if ((state_q == ARB_RESP) && (grant_q == IDX_W'(g))) begin
        if (resp_q.accept) acc_d = stat_sat_inc(acc_q);
        else               rej_d = stat_sat_inc(rej_q);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        acc_q <= '0;
        rej_q <= '0;
      end else begin
        acc_q <= acc_d;
        rej_q <= rej_d;
      end
    end

    assign stat_accept_o[g*XIF_ARB_STAT_W +: XIF_ARB_STAT_W] = acc_q;
    assign stat_reject_o[g*XIF_ARB_STAT_W +: XIF_ARB_STAT_W] = rej_q;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibex_xif_compressed_arbiter.sv
// ============================================================================
// Module : tb_ibex_xif_compressed_arbiter
// Brief  : Scoreboard bench for the compressed-interface arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_xif_compressed_arbiter;
  import ibex_xif_compressed_arbiter_pkg::*;

  typedef struct {
    logic [1:0]         gnt;
    x_compressed_resp_t resp;
  } exp_t;

  logic                            clk = 1'b0;
  logic                            rst_i;
  logic [1:0]                      req_valid_i;
  logic [1:0]                      req_ready_o;
  x_compressed_req_t [1:0]         req_i;
  x_compressed_resp_t              resp_o;
  logic                            dn_valid_o;
  logic                            dn_ready_i;
  x_compressed_req_t               dn_req_o;
  x_compressed_resp_t              dn_resp_i;
`ifdef XIF_COMP_ARB_STATS_EN
  logic [31:0]                     stat_accept_o;
  logic [31:0]                     stat_reject_o;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic dn_hold  = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ibex_xif_compressed_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_i       (req_i),
    .resp_o      (resp_o),
    .dn_valid_o  (dn_valid_o),
    .dn_ready_i  (dn_ready_i),
    .dn_req_o    (dn_req_o),
    .dn_resp_i   (dn_resp_i)
`ifdef XIF_COMP_ARB_STATS_EN
    ,
    .stat_accept_o (stat_accept_o),
    .stat_reject_o (stat_reject_o)
`endif
  );

  // Downstream decoder model: c.addi a0,1 decodes to addi a0,a0,1; other
  // encodings get a tagged expansion, accepted when bit 15 is clear.
  function automatic x_compressed_resp_t model(input logic [15:0] c);
    x_compressed_resp_t r;
    if (c == 16'h0505) begin
      r.instr  = 32'h00150513;
      r.accept = 1'b1;
    end else begin
      r.instr  = {16'hC0DE, c};
      r.accept = ~c[15];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    dn_ready_i = dn_valid_o && !dn_hold;
    dn_resp_i  = model(dn_req_o.instr);
  end

  // Output monitor: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_i) begin
      checks++;
      if (req_ready_o != 2'b00) begin
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ready: got ready=%b resp=%h, required no pulse", req_ready_o, resp_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (req_ready_o !== e.gnt || resp_o !== e.resp) begin
            failures++;
            $display("FAIL resp_pulse: got ready=%b resp=%h, required ready=%b resp=%h",
                     req_ready_o, resp_o, e.gnt, e.resp);
          end
        end
      end else if (resp_o !== '0) begin
        failures++;
        $display("FAIL resp_idle: got resp=%h, required 0 outside pulse", resp_o);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] gnt, input x_compressed_resp_t r);
    exp_t e;
    e.gnt  = gnt;
    e.resp = r;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] mask);
    req_valid_i = mask;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dn_valid_o) break;
    end
    req_valid_i = 2'b00;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_i       = 1'b1;
    req_valid_i = 2'b00;
    req_i       = '0;
    tick();
    tick();
    checks++;
    if (dn_valid_o !== 1'b0 || req_ready_o !== 2'b00 || resp_o !== '0 || dn_req_o !== '0) begin
      failures++;
      $display("FAIL reset_state: got dn_valid=%b ready=%b resp=%h dn_req=%h, required all 0",
               dn_valid_o, req_ready_o, resp_o, dn_req_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_single();
    x_compressed_req_t r;
    x_compressed_resp_t e;
    r.instr = 16'h0505; r.mode = 2'b01; r.id = 4'h3;
    e.instr = 32'h00150513; e.accept = 1'b1;
    req_i[0]    = r;
    req_valid_i = 2'b01;
    push(2'b01, e);
    tick();
    checks++;
    if (dn_valid_o !== 1'b1 || dn_req_o !== r) begin
      failures++;
      $display("FAIL single_issue: got dn_valid=%b dn_req=%h, required 1 %h", dn_valid_o, dn_req_o, r);
    end
    req_valid_i = 2'b00;
    tick();
    checks++;
    if (req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL single_latency: got ready=%b, required 01 two cycles after grant", req_ready_o);
    end
    wait_drain(4);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL single_drain: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_round_robin();
    int t[$];
    rst_i       = 1'b1;
    req_i[0].instr = 16'h0101;
    req_i[1].instr = 16'h0202;
    req_valid_i = 2'b11;
    for (int k = 0; k < 4; k++)
      push((k % 2 == 0) ? 2'b01 : 2'b10, model((k % 2 == 0) ? 16'h0101 : 16'h0202));
    tick();
    rst_i = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (req_ready_o != 2'b00) t.push_back(c);
      if (t.size() == 4) begin
        req_valid_i = 2'b00;
        break;
      end
    end
    checks++;
    if (t.size() != 4) begin
      failures++;
      $display("FAIL rr_count: got %0d pulses, required 4", t.size());
    end else begin
      checks++;
      if (t[0] != 2 || t[1] - t[0] != 3 || t[2] - t[1] != 3 || t[3] - t[2] != 3) begin
        failures++;
        $display("FAIL rr_spacing: got pulses at %0d %0d %0d %0d, required 2 5 8 11", t[0], t[1], t[2], t[3]);
      end
    end
    wait_drain(4);
  endtask

  task automatic test_timeout();
    int hi;
    int got;
    x_compressed_resp_t z;
    z       = '0;
    dn_hold = 1'b1;
    req_i[0].instr = 16'h0707;
    push(2'b01, z);
    drive(2'b01);
    hi  = dn_valid_o ? 1 : 0;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (req_ready_o != 2'b00) begin
        got = 1;
        break;
      end
      if (dn_valid_o) hi++;
    end
    checks++;
    if (got != 1 || hi != 16) begin
      failures++;
      $display("FAIL timeout_len: got pulse=%0d dn_valid_cycles=%0d, required 1 and 16", got, hi);
    end
    dn_hold     = 1'b0;
    req_i[1].instr = 16'h0303;
    push(2'b10, model(16'h0303));
    req_valid_i = 2'b11;
    tick();
    tick();
    req_valid_i = 2'b00;
    wait_drain(6);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL timeout_next_grant: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    dn_hold = 1'b1;
    drive(2'b01);
    tick();
    rst_i = 1'b1;
    tick();
    checks++;
    if (dn_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin
      failures++;
      $display("FAIL abort_reset: got dn_valid=%b ready=%b, required 0 00", dn_valid_o, req_ready_o);
    end
    rst_i   = 1'b0;
    dn_hold = 1'b0;
    pulses  = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (req_ready_o != 2'b00) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL abort_no_pulse: got %0d pulses, required 0", pulses);
    end
    req_i[0].instr = 16'h0404;
    push(2'b01, model(16'h0404));
    drive(2'b11);
    wait_drain(6);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL abort_ptr_reset: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_latched();
    int pulses;
    x_compressed_req_t r;
    r.instr = 16'h1234; r.mode = 2'b10; r.id = 4'h9;
    dn_hold  = 1'b1;
    req_i[0] = r;
    push(2'b01, model(16'h1234));
    drive(2'b01);
    req_i[0].instr = 16'hFFFF;
    req_i[0].id    = 4'h1;
    tick();
    checks++;
    if (dn_valid_o !== 1'b1 || dn_req_o !== r) begin
      failures++;
      $display("FAIL latched_req: got dn_valid=%b dn_req=%h, required 1 %h", dn_valid_o, dn_req_o, r);
    end
    dn_hold = 1'b0;
    pulses  = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (req_ready_o == 2'b01) pulses++;
    end
    checks++;
    if (pulses != 1 || sb.size() != 0) begin
      failures++;
      $display("FAIL latched_pulse: got %0d pulses %0d pending, required 1 0", pulses, sb.size());
    end
  endtask

`ifdef XIF_COMP_ARB_STATS_EN
  task automatic test_stats();
    x_compressed_resp_t z;
    z     = '0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_i[1].instr = 16'h0010 + 16'(k);
      push(2'b10, model(16'h0010 + 16'(k)));
      drive(2'b10);
      wait_drain(6);
    end
    dn_hold = 1'b1;
    push(2'b10, z);
    drive(2'b10);
    wait_drain(30);
    dn_hold = 1'b0;
    tick();
    checks++;
    if (stat_accept_o[31:16] !== 16'd3 || stat_reject_o[31:16] !== 16'd1 ||
        stat_accept_o[15:0] !== 16'd0 || stat_reject_o[15:0] !== 16'd0) begin
      failures++;
      $display("FAIL stats_count: got acc=%h rej=%h, required acc=00030000 rej=00010000",
               stat_accept_o, stat_reject_o);
    end
    force dut.g_stats[1].acc_q = 16'hFFFF;
    tick();
    release dut.g_stats[1].acc_q;
    req_i[1].instr = 16'h0020;
    push(2'b10, model(16'h0020));
    drive(2'b10);
    wait_drain(6);
    tick();
    checks++;
    if (stat_accept_o[31:16] !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_saturate: got %h, required ffff", stat_accept_o[31:16]);
    end
  endtask
`endif

  initial begin
    dn_ready_i  = 1'b0;
    dn_resp_i   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_abort();
    test_latched();
`ifdef XIF_COMP_ARB_STATS_EN
    test_stats();
`endif
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_drain: got %0d pending expectations, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
